// File: rtl/serial_adder_ctrl_if.sv
// Handshake/bus bundle for serial_adder_ctrl.
// The optional subtract request exists only when SERIAL_ADDSUB_EN is defined.
//
// Valid/ready rule for both channels: a transfer happens on a rising edge where
// valid and ready are both 1. Once the block raises done_valid it holds it, with
// sum/cout stable, until that transfer. start_ready is high exactly in IDLE.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDSUB_EN
  logic             sub;
`endif
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             done_valid;
  logic             done_ready;
  logic             busy;

  // Operand source / result consumer side
  modport master (
`ifdef SERIAL_ADDSUB_EN
    output sub,
`endif
    output start_valid, a, b, cin, done_ready,
    input  start_ready, sum, cout, done_valid, busy
  );

  // Adder controller side
  modport slave (
`ifdef SERIAL_ADDSUB_EN
    input  sub,
`endif
    input  start_valid, a, b, cin, done_ready,
    output start_ready, sum, cout, done_valid, busy
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder controller: one full_adder reused over WIDTH
// cycles, LSB first, with the carry held in a flop between bits.
// Optional feature macro: SERIAL_ADDSUB_EN (adds a subtract request on io.sub).
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  serial_adder_ctrl_if.slave io
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic fa_add;
  logic fa_cout;

  full_adder u_fa (
    .x   (a_sh_q[0]),
    .y   (b_sh_q[0]),
    .ci  (carry_q),
    .add (fa_add),
    .cout(fa_cout)
  );

  // State and datapath registers; reset abandons any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  // Next-state and datapath: load in IDLE, one bit per cycle in RUN, hold in DONE
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (io.start_valid) begin
          a_sh_d  = io.a;
          b_sh_d  = io.b;
          carry_d = io.cin;
`ifdef SERIAL_ADDSUB_EN
          // a - b computed as a + ~b + 1; cin has no meaning here
          if (io.sub) begin
            b_sh_d  = ~io.b;
            carry_d = 1'b1;
          end
`endif
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        sum_d   = {fa_add, sum_q[WIDTH-1:1]};
        carry_d = fa_cout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          cout_d  = fa_cout;
          state_d = DONE;
        end
      end
      DONE: begin
        if (io.done_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign io.start_ready = (state_q == IDLE);
  assign io.busy        = (state_q != IDLE);
  assign io.done_valid  = (state_q == DONE);
  assign io.sum         = sum_q;
  assign io.cout        = cout_q;

endmodule

// One-bit full adder shared across all bit positions.
module full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic add,
  output logic cout
);
  assign add  = x ^ y ^ ci;
  assign cout = (x & y) | (x & ci) | (y & ci);
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH=8.
module tb_serial_adder_ctrl;

  localparam int WIDTH = 8;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   cyc;

  logic [WIDTH:0] exp_q[$];

  serial_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .rst(rst),
    .io (bus)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle: step past the edge; inputs are then driven and outputs sampled
  task automatic tick();
    @(posedge clk);
    #1;
    cyc = cyc + 1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present operands for one cycle; the edge at the end of it accepts them
  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin);
    bus.a           = a;
    bus.b           = b;
    bus.cin         = cin;
    bus.start_valid = 1'b1;
    tick();
    bus.start_valid = 1'b0;
  endtask

  // Count cycles after acceptance until done_valid; bounded
  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.done_valid && lat < 40) begin
      tick();
      lat = lat + 1;
    end
  endtask

  // Run one full operation and check result, latency and handshake release
  task automatic do_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic cin, input logic [WIDTH-1:0] exp_sum, input logic exp_cout);
    int lat;
    start_op(a, b, cin);
    check({tag, ".busy_run"}, 32'(bus.busy), 32'd1);
    wait_done(lat);
    check({tag, ".latency"}, 32'(lat), 32'(WIDTH));
    check({tag, ".sum"}, 32'(bus.sum), 32'(exp_sum));
    check({tag, ".cout"}, 32'(bus.cout), 32'(exp_cout));
    bus.done_ready = 1'b1;
    tick();
    bus.done_ready = 1'b0;
    check({tag, ".idle_after"}, 32'({bus.start_ready, bus.busy, bus.done_valid}), 32'b100);
  endtask

  initial begin
    int lat;
    int results;
    int idx;
    int t_done[3];
    logic [WIDTH-1:0] pa[3];
    logic [WIDTH-1:0] pb[3];
    logic             pc[3];
    logic [WIDTH:0]   exp_v;

    errors = 0;
    checks = 0;
    cyc    = 0;
    rst             = 1'b1;
    bus.start_valid = 1'b0;
    bus.a           = '0;
    bus.b           = '0;
    bus.cin         = 1'b0;
    bus.done_ready  = 1'b0;
`ifdef SERIAL_ADDSUB_EN
    bus.sub         = 1'b0;
`endif

    // Reset
    tick();
    tick();
    rst = 1'b0;
    check("reset.start_ready", 32'(bus.start_ready), 32'd1);
    check("reset.busy", 32'(bus.busy), 32'd0);
    check("reset.done_valid", 32'(bus.done_valid), 32'd0);
    check("reset.sum", 32'(bus.sum), 32'd0);
    check("reset.cout", 32'(bus.cout), 32'd0);

    // Basic additions
    do_op("add_35_4a", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0);
    do_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    do_op("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

    // Backpressure: result held, new operands ignored
    start_op(8'h12, 8'h34, 1'b0);
    wait_done(lat);
    check("bp.latency", 32'(lat), 32'(WIDTH));
    for (int i = 0; i < 5; i++) begin
      bus.a           = 8'hAA;
      bus.b           = 8'h55;
      bus.start_valid = 1'b1;
      tick();
      check("bp.done_valid", 32'(bus.done_valid), 32'd1);
      check("bp.sum", 32'(bus.sum), 32'h46);
      check("bp.cout", 32'(bus.cout), 32'd0);
      check("bp.start_ready", 32'(bus.start_ready), 32'd0);
    end
    bus.start_valid = 1'b0;
    bus.done_ready  = 1'b1;
    tick();
    bus.done_ready  = 1'b0;
    check("bp.idle", 32'(bus.start_ready), 32'd1);
    do_op("bp_next_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);

    // Reset during the third RUN cycle
    start_op(8'h0F, 8'h0F, 1'b0);
    tick();
    tick();
    check("rstrun.busy_before", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstrun.start_ready", 32'(bus.start_ready), 32'd1);
    check("rstrun.done_valid", 32'(bus.done_valid), 32'd0);
    check("rstrun.sum", 32'(bus.sum), 32'd0);
    check("rstrun.cout", 32'(bus.cout), 32'd0);
    do_op("after_rst_01_01", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);

    // Back-to-back with start_valid and done_ready held high
    pa[0] = 8'h01; pb[0] = 8'h02; pc[0] = 1'b0;
    pa[1] = 8'h7F; pb[1] = 8'h01; pc[1] = 1'b1;
    pa[2] = 8'hC0; pb[2] = 8'h50; pc[2] = 1'b0;
    idx = 0;
    results = 0;
    bus.done_ready = 1'b1;
    for (int n = 0; n < 80 && results < 3; n++) begin
      if (bus.done_valid) begin
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        check("b2b.sum", 32'(bus.sum), 32'(exp_v[WIDTH-1:0]));
        check("b2b.cout", 32'(bus.cout), 32'(exp_v[WIDTH]));
        t_done[results] = cyc;
        results = results + 1;
      end
      if (idx < 3) begin
        bus.a           = pa[idx];
        bus.b           = pb[idx];
        bus.cin         = pc[idx];
        bus.start_valid = 1'b1;
        if (bus.start_ready) begin
          exp_q.push_back({1'b0, pa[idx]} + {1'b0, pb[idx]} + {{WIDTH{1'b0}}, pc[idx]});
          idx = idx + 1;
        end
      end else begin
        bus.start_valid = 1'b0;
      end
      tick();
    end
    bus.start_valid = 1'b0;
    bus.done_ready  = 1'b0;
    check("b2b.results", 32'(results), 32'd3);
    if (results == 3) begin
      check("b2b.spacing01", 32'(t_done[1] - t_done[0]), 32'(WIDTH + 2));
      check("b2b.spacing12", 32'(t_done[2] - t_done[1]), 32'(WIDTH + 2));
    end
    tick();
    tick();
    check("b2b.idle", 32'({bus.start_ready, bus.busy}), 32'b10);

`ifdef SERIAL_ADDSUB_EN
    // Subtraction: cout=1 means no borrow
    bus.sub = 1'b1;
    do_op("sub_10_01", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b1);
    do_op("sub_00_01", 8'h00, 8'h01, 1'b1, 8'hFF, 1'b0);
    bus.sub = 1'b0;
    do_op("sub0_add", 8'h10, 8'h01, 1'b0, 8'h11, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial N-bit adder controller. It time-multiplexes a single `full_adder` instance across WIDTH bit positions, LSB first, keeping the carry in a flip-flop between cycles. Operands are accepted on a valid/ready start handshake and the result is returned on a valid/ready done handshake. It is the area-minimal alternative to a ripple-carry array and sits between an operand source and a result consumer.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start_valid  input  1  a, b and cin are valid.
- start_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- sum  output  WIDTH  result, registered.
- cout  output  1  final carry-out, registered.
- done_valid  output  1  sum and cout are valid.
- done_ready  input  1  consumer accepts the result.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (rst=1 at an edge):
  - state becomes IDLE; sum=0, cout=0, done_valid=0, busy=0.
  - start_ready=1 from the first cycle after reset.
  - Reset mid-RUN or mid-DONE abandons the operation; no result is presented.
  - rst has priority over every other input.
- States: IDLE, RUN, DONE. Encoding is free.
- IDLE:
  - start_ready=1.
  - On start_valid=1 at an edge: a_sh<=a, b_sh<=b, carry<=cin, bit count<=0, state<=RUN.
  - sum and cout keep their previous values until overwritten.
- RUN (one bit per cycle):
  - The `full_adder` inputs are a_sh[0], b_sh[0] and carry.
  - At each edge: a_sh and b_sh shift right by 1; the adder's `add` output shifts into sum at bit WIDTH-1 (sum shifts right); carry<=cout of the adder; count increments.
  - When count==WIDTH-1 at an edge: the cout output register <= the adder's cout, state<=DONE.
  - start_valid is ignored in RUN.
- DONE:
  - done_valid=1; sum and cout are stable.
  - Transfer occurs when done_valid and done_ready are both 1 at an edge; then state<=IDLE.
  - done_ready may be held high in advance; it is sampled only in DONE.
- Latency:
  - Start accepted at edge T.
  - RUN occupies cycles T+1..T+WIDTH.
  - done_valid is high from cycle T+WIDTH+1.
  - Minimum start-to-start spacing is WIDTH+2 cycles. A new start cannot be accepted in the same cycle as a done transfer.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). No saturation.
- busy = (state != IDLE). start_ready = (state == IDLE).
- Holding start_valid high continuously in IDLE starts a new operation every WIDTH+2 cycles, provided done_ready is held high.

Optional Feature:
Macro: SERIAL_ADDSUB_EN.
- Defined:
  - Adds input port `sub` (1 bit), sampled at start acceptance.
  - sub=1: b_sh<=~b, carry<=1, and cin is ignored. Result is a-b in two's complement; cout=1 means no borrow.
  - sub=0: identical to add.
- Undefined: no `sub` port; add only. The port list and behaviour are exactly as specified above.

Test Plan:
- WIDTH=8; a=0x35, b=0x4A, cin=0, accepted at T -> sum=0x7F, cout=0; done_valid first high at T+9; busy high T+1..T+9.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Backpressure: hold done_ready=0 for 5 cycles in DONE and pulse start_valid with new operands -> done_valid, sum and cout held; start_ready=0; new operands ignored. After done_ready=1 -> IDLE, then the next start is accepted.
- Assert rst in the 3rd RUN cycle -> next cycle: IDLE, done_valid=0, sum=0, cout=0, start_ready=1. A following start 0x01+0x01 -> sum=0x02, cout=0.
- Back-to-back: start_valid and done_ready held at 1 with 3 operand pairs -> 3 results in order; done_valid pulses spaced exactly 10 cycles apart.
- With SERIAL_ADDSUB_EN: a=0x10, b=0x01, sub=1 -> sum=0x0F, cout=1. a=0x00, b=0x01, sub=1 -> sum=0xFF, cout=0.
